// File: rtl/tage_pkg.sv
// tage_pkg
// Shared types and constants for the TAGE training-update controller.
//   tage_upd_state_t : controller FSM states (INIT, IDLE, PROBE, COMMIT)
//   tage_upd_t       : latched resolved-branch update request
//   LFSR_SEED/TAPS   : 8-bit LFSR used for randomised allocation choice
//                      (x^8+x^6+x^5+x^4+1), only used when TAGE_ALLOC_RAND_EN
//                      is defined.
// The struct is sized from the TAGE_* constants below; the controller's
// NUM_TABLES/IDX_W/TAG_W parameters default to these values and must match.
package tage_pkg;

    localparam int TAGE_NUM_TABLES = 4;
    localparam int TAGE_IDX_W      = 6;
    localparam int TAGE_TAG_W      = 9;
    localparam int TAGE_PROV_W     = $clog2(TAGE_NUM_TABLES + 1);

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_PROBE  = 2'd2,
        ST_COMMIT = 2'd3
    } tage_upd_state_t;

    typedef struct packed {
        logic [TAGE_PROV_W-1:0]                provider;
        logic                                  provTaken;
        logic                                  altTaken;
        logic                                  taken;
        logic [TAGE_NUM_TABLES*TAGE_IDX_W-1:0] idx;
        logic [TAGE_NUM_TABLES*TAGE_TAG_W-1:0] tag;
    } tage_upd_t;

    // Fibonacci LFSR, shift left, feedback from bits 7,5,4,3.
    localparam logic [7:0] LFSR_SEED = 8'h01;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/tage_update_ctrl_if.sv
// tage_update_ctrl_if
// Bundles the resolve-side update request and the per-table write ports.
//   IN_upd*          : update request (valid/ready handshake, see below)
//   IN_allocAvail    : per-table "useful == 0" at the driven address
//   OUT_write*, OUT_doAlloc, OUT_allocFailed : per-table write strobes
//   OUT_writeAddr/Tag/Taken : write address/tag/outcome
//   OUT_dbgState, OUT_dbgAvail : controller FSM state and probed availability
// Handshake: a request transfers on a rising clk edge where IN_updValid and
// OUT_updReady are both 1; the request fields must be stable while
// IN_updValid is high, and OUT_updReady does not depend on IN_updValid.
// Modports: master = resolve path / tables side, slave = controller.
interface tage_update_ctrl_if
    import tage_pkg::*;
#(
    parameter int NUM_TABLES = 4,
    parameter int IDX_W      = 6,
    parameter int TAG_W      = 9
) ();
    localparam int PROV_W = $clog2(NUM_TABLES + 1);

    logic                        IN_updValid;
    logic                        OUT_updReady;
    logic [PROV_W-1:0]           IN_updProvider;
    logic                        IN_updProvTaken;
    logic                        IN_updAltTaken;
    logic                        IN_updTaken;
    logic [NUM_TABLES*IDX_W-1:0] IN_updIdx;
    logic [NUM_TABLES*TAG_W-1:0] IN_updTag;
    logic [NUM_TABLES-1:0]       IN_allocAvail;

    logic [NUM_TABLES-1:0]       OUT_writeValid;
    logic [NUM_TABLES-1:0]       OUT_writeUpdate;
    logic [NUM_TABLES-1:0]       OUT_writeUseful;
    logic [NUM_TABLES-1:0]       OUT_writeCorrect;
    logic [NUM_TABLES-1:0]       OUT_doAlloc;
    logic [NUM_TABLES-1:0]       OUT_allocFailed;
    logic [NUM_TABLES*IDX_W-1:0] OUT_writeAddr;
    logic [NUM_TABLES*TAG_W-1:0] OUT_writeTag;
    logic                        OUT_writeTaken;

    tage_upd_state_t             OUT_dbgState;
    logic [NUM_TABLES-1:0]       OUT_dbgAvail;

    modport master (
        output IN_updValid, IN_updProvider, IN_updProvTaken, IN_updAltTaken,
               IN_updTaken, IN_updIdx, IN_updTag, IN_allocAvail,
        input  OUT_updReady, OUT_writeValid, OUT_writeUpdate, OUT_writeUseful,
               OUT_writeCorrect, OUT_doAlloc, OUT_allocFailed, OUT_writeAddr,
               OUT_writeTag, OUT_writeTaken, OUT_dbgState, OUT_dbgAvail
    );

    modport slave (
        input  IN_updValid, IN_updProvider, IN_updProvTaken, IN_updAltTaken,
               IN_updTaken, IN_updIdx, IN_updTag, IN_allocAvail,
        output OUT_updReady, OUT_writeValid, OUT_writeUpdate, OUT_writeUseful,
               OUT_writeCorrect, OUT_doAlloc, OUT_allocFailed, OUT_writeAddr,
               OUT_writeTag, OUT_writeTaken, OUT_dbgState, OUT_dbgAvail
    );

endinterface

// File: rtl/tage_alloc_pick.sv
// tage_alloc_pick
// Combinational priority picker for the allocation target.
//   IN_avail   : available tables (bit i = table i+1)
//   IN_skip    : choose the second-lowest available table when at least two
//                are available
//   OUT_choice : one-hot choice, zero when nothing is available
module tage_alloc_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] IN_avail,
    input  logic         IN_skip,
    output logic [N-1:0] OUT_choice
);
    logic [N-1:0] first;
    logic [N-1:0] rest;
    logic [N-1:0] second;

    // x & -x isolates the lowest set bit.
    assign first  = IN_avail & (~IN_avail + N'(1));
    assign rest   = IN_avail & ~first;
    assign second = rest & (~rest + N'(1));

    assign OUT_choice = (IN_skip && (rest != '0)) ? second : first;

endmodule

// File: rtl/tage_update_ctrl.sv
// tage_update_ctrl
// Sequences TAGE tagged-table training writes after branch resolution.
// Correct prediction: provider-only update. Misprediction with a provider
// below the longest table: probe useful counters of longer tables, then
// allocate one entry or flag allocation failure on all longer tables.
//   clk, rst : clock, synchronous active-high reset
//   bus      : tage_update_ctrl_if.slave (request, table write ports, debug)
// Optional feature macro: TAGE_ALLOC_RAND_EN -- LFSR-driven choice between
// the lowest and second-lowest available table.
module tage_update_ctrl
    import tage_pkg::*;
#(
    parameter int NUM_TABLES  = TAGE_NUM_TABLES,
    parameter int IDX_W       = TAGE_IDX_W,
    parameter int TAG_W       = TAGE_TAG_W,
    parameter int INIT_CYCLES = 64
) (
    input logic clk,
    input logic rst,
    tage_update_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(INIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);

    tage_upd_state_t       state;
    logic [CNT_W-1:0]      initCnt;
    tage_upd_t             held;
    tage_upd_t             reqIn;
    tage_upd_t             src;
    logic [NUM_TABLES-1:0] availReg;

    logic [NUM_TABLES-1:0] wValid, wUpdate, wUseful, wCorrect, wAlloc, wFailed;
    logic [NUM_TABLES-1:0] nValid, nUpdate, nUseful, nCorrect, nAlloc, nFailed;

    logic                  srcMiss;
    logic                  allocPath;
    logic                  pickSkip;
    logic [NUM_TABLES-1:0] aboveMask;
    logic [NUM_TABLES-1:0] probeAvail;
    logic [NUM_TABLES-1:0] pickOneHot;

    always_comb begin
        reqIn           = '0;
        reqIn.provider  = bus.IN_updProvider;
        reqIn.provTaken = bus.IN_updProvTaken;
        reqIn.altTaken  = bus.IN_updAltTaken;
        reqIn.taken     = bus.IN_updTaken;
        reqIn.idx       = bus.IN_updIdx;
        reqIn.tag       = bus.IN_updTag;
    end

    // Commit strobes are computed one cycle early and registered: from the
    // live request when going IDLE->COMMIT, from the held request in PROBE.
    assign src       = (state == ST_IDLE) ? reqIn : held;
    assign srcMiss   = (src.provTaken != src.taken);
    assign allocPath = (state == ST_PROBE) && srcMiss &&
                       (int'(src.provider) < NUM_TABLES);

    always_comb begin
        aboveMask = '0;
        for (int i = 0; i < NUM_TABLES; i++) begin
            aboveMask[i] = (i >= int'(src.provider));
        end
    end

    assign probeAvail = bus.IN_allocAvail & aboveMask;

`ifdef TAGE_ALLOC_RAND_EN
    logic [7:0] lfsr;
    logic [7:0] lfsrNext;

    assign lfsrNext = lfsr_step(lfsr);

    always_ff @(posedge clk) begin
        if (rst) lfsr <= LFSR_SEED;
        else     lfsr <= lfsrNext;
    end

    // Strobes are registered at the PROBE->COMMIT edge, so the value the
    // LFSR holds during COMMIT is lfsrNext.
    assign pickSkip = lfsrNext[0];
`else
    assign pickSkip = 1'b0;
`endif

    tage_alloc_pick #(.N(NUM_TABLES)) u_pick (
        .IN_avail   (probeAvail),
        .IN_skip    (pickSkip),
        .OUT_choice (pickOneHot)
    );

    always_comb begin
        nValid   = '0;
        nUpdate  = '0;
        nUseful  = '0;
        nCorrect = '0;
        nAlloc   = '0;
        nFailed  = '0;
        for (int i = 0; i < NUM_TABLES; i++) begin
            if ((src.provider != '0) && (i == int'(src.provider) - 1)) begin
                nValid[i]   = 1'b1;
                nUpdate[i]  = 1'b1;
                nUseful[i]  = (src.provTaken != src.altTaken);
                nCorrect[i] = !srcMiss;
            end
        end
        // Allocation only targets tables above the provider, so it never
        // collides with the provider update in the same cycle.
        if (allocPath) begin
            if (probeAvail != '0) begin
                nValid = nValid | pickOneHot;
                nAlloc = pickOneHot;
            end else begin
                nValid  = nValid | aboveMask;
                nFailed = aboveMask;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_INIT;
            initCnt  <= '0;
            held     <= '0;
            availReg <= '0;
            wValid   <= '0;
            wUpdate  <= '0;
            wUseful  <= '0;
            wCorrect <= '0;
            wAlloc   <= '0;
            wFailed  <= '0;
        end else begin
            wValid   <= '0;
            wUpdate  <= '0;
            wUseful  <= '0;
            wCorrect <= '0;
            wAlloc   <= '0;
            wFailed  <= '0;
            case (state)
                ST_INIT: begin
                    if (initCnt == INIT_LAST) state <= ST_IDLE;
                    else                      initCnt <= initCnt + CNT_W'(1);
                end
                ST_IDLE: begin
                    if (bus.IN_updValid) begin
                        held <= reqIn;
                        if (srcMiss && (int'(reqIn.provider) < NUM_TABLES)) begin
                            state <= ST_PROBE;
                        end else begin
                            state    <= ST_COMMIT;
                            wValid   <= nValid;
                            wUpdate  <= nUpdate;
                            wUseful  <= nUseful;
                            wCorrect <= nCorrect;
                            wAlloc   <= nAlloc;
                            wFailed  <= nFailed;
                        end
                    end
                end
                ST_PROBE: begin
                    availReg <= probeAvail;
                    state    <= ST_COMMIT;
                    wValid   <= nValid;
                    wUpdate  <= nUpdate;
                    wUseful  <= nUseful;
                    wCorrect <= nCorrect;
                    wAlloc   <= nAlloc;
                    wFailed  <= nFailed;
                end
                ST_COMMIT: state <= ST_IDLE;
                default:   state <= ST_INIT;
            endcase
        end
    end

    assign bus.OUT_updReady     = (state == ST_IDLE);
    assign bus.OUT_writeValid   = wValid;
    assign bus.OUT_writeUpdate  = wUpdate;
    assign bus.OUT_writeUseful  = wUseful;
    assign bus.OUT_writeCorrect = wCorrect;
    assign bus.OUT_doAlloc      = wAlloc;
    assign bus.OUT_allocFailed  = wFailed;
    assign bus.OUT_writeAddr    = held.idx;
    assign bus.OUT_writeTag     = held.tag;
    assign bus.OUT_writeTaken   = held.taken;
    assign bus.OUT_dbgState     = state;
    assign bus.OUT_dbgAvail     = availReg;

endmodule

// File: doc/tage_update_ctrl.md
# tage_update_ctrl

Sequences training writes into the tagged TAGE tables after branch resolution. It accepts one resolved-branch update at a time and drives the per-table write ports. On a correct prediction it updates only the provider. On a misprediction it first probes the useful counters of all longer-history tables, then either allocates one entry or ages the candidates. It sits between the branch-resolve path and the array of tagged tables.

## Interface
Parameters:
- NUM_TABLES, 4, number of tagged tables; table numbers 1..NUM_TABLES, longer history = higher number
- IDX_W, 6, table index width
- TAG_W, 9, tag width
- INIT_CYCLES, 64, cycles after reset during which tables run their clear sweep

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- IN_updValid  in  1  update request valid
- OUT_updReady  out  1  controller can accept a request
- IN_updProvider  in  $clog2(NUM_TABLES+1)  providing table number; 0 = base predictor
- IN_updProvTaken  in  1  provider prediction
- IN_updAltTaken  in  1  alternate prediction
- IN_updTaken  in  1  actual outcome
- IN_updIdx  in  NUM_TABLES*IDX_W  per-table index; slice i-1 belongs to table i
- IN_updTag  in  NUM_TABLES*TAG_W  per-table tag
- IN_allocAvail  in  NUM_TABLES  per-table "useful == 0" at the driven address (combinational)
- OUT_writeValid, OUT_writeUpdate, OUT_writeUseful, OUT_writeCorrect, OUT_doAlloc, OUT_allocFailed  out  NUM_TABLES each  per-table write strobes/qualifiers
- OUT_writeAddr  out  NUM_TABLES*IDX_W  per-table address, also used for probing
- OUT_writeTag  out  NUM_TABLES*TAG_W  per-table tag
- OUT_writeTaken  out  1  outcome, shared by all tables

## Operation
- States: INIT, IDLE, PROBE, COMMIT.
- INIT is entered on reset. A counter runs for INIT_CYCLES cycles, then the FSM moves to IDLE.
- OUT_updReady = (state == IDLE). A request is accepted on IN_updValid && OUT_updReady and latched into a holding register.
- mispredict = (IN_updProvTaken != IN_updTaken). With provider 0, the base prediction is passed in on IN_updProvTaken.
- From IDLE on accept:
  - PROBE if mispredict and provider < NUM_TABLES.
  - Otherwise COMMIT.
- In PROBE:
  - OUT_writeAddr carries the latched indices; all OUT_writeValid = 0.
  - The bits of IN_allocAvail at table numbers > provider are sampled into availReg.
- In COMMIT, for one cycle, with OUT_writeAddr and OUT_writeTag still driven:
  - Provider update (provider ≠ 0):
    - writeValid[p] = writeUpdate[p] = 1.
    - writeUseful[p] = (provTaken != altTaken).
    - writeCorrect[p] = !mispredict.
  - Allocation (mispredict, provider < NUM_TABLES):
    - If availReg ≠ 0: pick table j (see Configuration); writeValid[j] = doAlloc[j] = 1, writeUpdate[j] = 0.
    - Else: writeValid = allocFailed = 1 for every table > provider.
  - OUT_writeTaken = latched outcome.
- After COMMIT the FSM returns to IDLE.
- The provider update and the allocation target distinct tables, so they are issued in the same COMMIT cycle.
- Mispredict with provider == NUM_TABLES: update only, no probe, no alloc/fail.
- Bits for tables not written are 0 on every strobe output.

## Timing
- Reset values:
  - OUT_updReady = 0 and all strobes 0.
  - OUT_writeAddr, OUT_writeTag and OUT_writeTaken = 0.
- Correct path: accept at cycle N, COMMIT at N+1, ready again at N+2.
- Mispredict path: accept at N, PROBE at N+1, COMMIT at N+2, ready at N+3.
- rst mid-operation drops the held request and re-enters INIT; no strobe is asserted in the cycle after rst.
- IN_allocAvail is ignored outside PROBE.

## Configuration
- TAGE_ALLOC_RAND_EN defined:
  - An 8-bit LFSR (x^8+x^6+x^5+x^4+1) is reset to 8'h01 and steps every cycle.
  - If LFSR[0] = 1 in COMMIT and availReg has ≥2 bits set, the second-lowest available table is chosen; otherwise the lowest.
- TAGE_ALLOC_RAND_EN undefined: no LFSR; always the lowest available table above the provider.

## Structure
- Shared package tage_pkg holds:
  - the state enum tage_upd_state_t;
  - struct tage_upd_t (provider, provTaken, altTaken, taken, idx, tag);
  - the LFSR seed/taps constants.
- Sub-module tage_alloc_pick: availability vector plus skip bit in, one-hot choice out (combinational priority picker).

## Test plan
- Reset, then hold IN_updValid=1 → OUT_updReady stays 0 for 64 cycles, goes 1 at cycle 65 after reset release.
- Provider=2, provTaken=1, altTaken=0, taken=1 → COMMIT one cycle after accept with writeValid=4'b0010, writeUseful[1]=1, writeCorrect[1]=1; no alloc.
- Provider=1, mispredict, allocAvail=4'b1100 during PROBE, macro undefined → COMMIT writeValid=4'b0101, doAlloc=4'b0100, writeUpdate=4'b0001, writeCorrect[0]=0.
- Provider=1, mispredict, allocAvail=4'b0000 → COMMIT allocFailed=4'b1110, writeValid=4'b1111, doAlloc=0.
- Provider=4, mispredict → no PROBE; COMMIT writeValid=4'b1000 only; ready again two cycles after accept.
- rst asserted during PROBE → all strobes 0 next cycle; FSM re-enters INIT; the request is never committed.
